// File: rtl/mem_stream_pkg.sv
// Shared types and constants for the memory stream reader.
package mem_stream_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        FINISH
    } stream_state_t;

endpackage

// File: rtl/stream_fifo2.sv
// Two-entry byte FIFO between the memory read pipeline and the output stream.
// A pop against an empty FIFO is ignored, so a push into an empty FIFO
// never passes through to the head in the same cycle.
module stream_fifo2
    import mem_stream_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [1:0]        count,
    output logic [DATA_W-1:0] head
);

    logic [DATA_W-1:0] entry_q [2];
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [1:0]        count_q;
    logic              do_push;
    logic              do_pop;

    assign do_pop  = pop && (count_q != 2'd0);
    assign do_push = push && ((count_q != 2'd2) || do_pop);
    assign count   = count_q;
    assign head    = entry_q[rd_ptr_q];

    // Storage, pointers and occupancy update on push/pop.
    always_ff @(posedge clk) begin
        if (!rst) begin
            // NOTE: the two entries are reset because the head drives the stream data port, which must read 0 after reset.
            entry_q[0] <= '0;
            entry_q[1] <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
            if (do_push) begin
                entry_q[wr_ptr_q] <= push_data;
                wr_ptr_q          <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/mem_stream_reader.sv
// Sequential read-out engine: walks a contiguous range of byte memory and
// streams each byte on a valid/ready port at one byte per cycle.
// Optional feature: define MEM_STREAM_CHECKSUM_EN to build the 16-bit
// running byte-sum accumulator on the checksum port.
module mem_stream_reader
    import mem_stream_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] length,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic [15:0]       checksum
);

    stream_state_t     state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] last_addr_q;
    logic [ADDR_W-1:0] issue_left_q;
    logic              pending_q;

    logic [1:0]        fifo_count;
    logic [DATA_W-1:0] fifo_head;
    logic              pop;
    logic              issue;
    logic              drain_empty;
    logic [2:0]        occupancy;

    stream_fifo2 u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (pending_q),
        .push_data (mem_data),
        .pop       (pop),
        .count     (fifo_count),
        .head      (fifo_head)
    );

    assign out_valid = (fifo_count != 2'd0);
    assign out_data  = fifo_head;
    assign pop       = out_valid && out_ready;
    assign busy      = (state_q == RUN) || (state_q == DRAIN);
    assign mem_req   = busy;
    assign done      = (state_q == FINISH);

    // Issue decision: a read is launched only if its byte will find FIFO room,
    // counting the read already in flight and any byte leaving this cycle.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        occupancy   = {1'b0, fifo_count} + {2'b00, pending_q};
        issue       = 1'b0;
        drain_empty = 1'b0;
        mem_addr    = last_addr_q;
        if ((state_q == RUN) && (issue_left_q != '0) &&
            (occupancy < (3'd2 + {2'b00, pop}))) begin
            issue = 1'b1;
        end
        if (!pending_q && ((fifo_count == 2'd0) || ((fifo_count == 2'd1) && pop))) begin
            drain_empty = 1'b1;
        end
        if (state_q == IDLE) begin
            mem_addr = '0;
        end else if (issue) begin
            mem_addr = addr_q;
        end
    end

    // Transfer FSM plus read-issue bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            last_addr_q  <= '0;
            issue_left_q <= '0;
            pending_q    <= 1'b0;
        end else begin
            pending_q <= issue;
            if (issue) begin
                last_addr_q  <= addr_q;
                addr_q       <= addr_q + ADDR_ONE;
                issue_left_q <= issue_left_q - ADDR_ONE;
            end
            case (state_q)
                IDLE: begin
                    if (start) begin
                        addr_q       <= base_addr;
                        issue_left_q <= length;
                        state_q      <= (length != '0) ? RUN : FINISH;
                    end
                end
                RUN: begin
                    if (issue && (issue_left_q == ADDR_ONE)) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (drain_empty) begin
                        state_q <= FINISH;
                    end
                end
                FINISH: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef MEM_STREAM_CHECKSUM_EN
    logic [15:0] sum_q;

    // Running wrap-around sum of handshaken bytes, cleared on an accepted start.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sum_q <= '0;
        end else if ((state_q == IDLE) && start) begin
            sum_q <= '0;
        end else if (pop) begin
            sum_q <= sum_q + {{(16-DATA_W){1'b0}}, fifo_head};
        end
    end

    assign checksum = sum_q;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_mem_stream_reader.sv
// Testbench for mem_stream_reader: byte memory model with one-cycle read
// latency, expected byte stream and checksum derived from memory contents.
module tb_mem_stream_reader;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] base_addr;
    logic [15:0] length;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;
    logic [15:0] checksum;

    logic [7:0]  mem [0:65535];

    int checks;
    int errors;

    mem_stream_reader dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done),
        .checksum  (checksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read data memory: data appears the cycle after the address.
    always @(posedge clk) mem_data <= mem[mem_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One complete transfer. mode 0: ready always high; 1: ready 1,0,0 repeating;
    // 2: random ready. inject pulses a conflicting start mid-transfer.
    task automatic run_xfer(input logic [15:0] base, input logic [15:0] len,
                            input int mode, input bit inject);
        logic [7:0]  exp_q [$];
        logic [15:0] exp_sum;
        logic [7:0]  held;
        bit          stalled;
        bit          seen_done;
        int          k;
        int          rx;
        int          first_valid;
        int          last_hs;
        int          budget;
        exp_sum = 16'h0000;
        for (int i = 0; i < int'(len); i++) begin
            exp_q.push_back(mem[16'(base + 16'(i))]);
            exp_sum = 16'(exp_sum + {8'h00, mem[16'(base + 16'(i))]});
        end
`ifndef MEM_STREAM_CHECKSUM_EN
        exp_sum = 16'h0000;
`endif
        budget      = 4 * int'(len) + 20;
        stalled     = 1'b0;
        seen_done   = 1'b0;
        held        = 8'h00;
        rx          = 0;
        first_valid = -1;
        last_hs     = -1;
        start     = 1'b1;
        base_addr = base;
        length    = len;
        @(posedge clk); #1;
        start     = 1'b0;
        base_addr = 16'($urandom);
        length    = 16'($urandom);
        k = 1;
        while (!seen_done && k < budget) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ((k - 1) % 3 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (inject && k == 5) begin
                start     = 1'b1;
                base_addr = 16'(base + 16'h0100);
                length    = 16'd3;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (k == 1 && len != 16'd0) begin
                check("first_mem_addr", mem_addr, base);
                check("busy_cycle1", busy, 1'b1);
                check("mem_req_cycle1", mem_req, 1'b1);
            end
            if (len == 16'd0) begin
                check("len0_no_valid", out_valid, 1'b0);
                check("len0_not_busy", busy, 1'b0);
            end
            if (stalled) check("stall_hold", out_data, held);
            if (out_valid && first_valid < 0) first_valid = k;
            if (out_valid && out_ready) begin
                rx++;
                last_hs = k;
                if (exp_q.size() == 0) check("byte_count", rx, len);
                else check("byte", out_data, exp_q.pop_front());
            end
            stalled = out_valid && !out_ready;
            held    = out_data;
            if (done) begin
                seen_done = 1'b1;
                check("busy_at_done", busy, 1'b0);
                check("bytes_left_at_done", exp_q.size(), 0);
                check("checksum", checksum, exp_sum);
                if (mode == 0) check("done_cycle", k, (len == 16'd0) ? 1 : int'(len) + 3);
            end
            @(posedge clk); #1;
            k++;
        end
        check("done_seen", seen_done, 1'b1);
        if (mode == 0 && len != 16'd0) begin
            check("first_valid_cycle", first_valid, 3);
            check("last_hs_cycle", last_hs, int'(len) + 2);
        end
        start = 1'b0;
        @(negedge clk);
        check("done_one_cycle", done, 1'b0);
        check("idle_no_valid", out_valid, 1'b0);
        check("checksum_hold", checksum, exp_sum);
        @(posedge clk); #1;
    endtask

    initial begin
        int hs;
        checks    = 0;
        errors    = 0;
        rst       = 1'b0;
        start     = 1'b0;
        base_addr = 16'h0000;
        length    = 16'h0000;
        out_ready = 1'b0;
        for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
        for (int a = 0; a < 4; a++) mem[16'h0040 + a] = 8'(8'h10 + a);

        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_mem_addr", mem_addr, 16'h0000);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 8'h00);
        check("rst_done", done, 1'b0);
        check("rst_checksum", checksum, 16'h0000);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // Preloaded bytes, full throughput, then with stalls.
        run_xfer(16'h0040, 16'd4, 0, 1'b0);
`ifdef MEM_STREAM_CHECKSUM_EN
        check("checksum_known", checksum, 16'h0046);
`endif
        run_xfer(16'h0040, 16'd4, 1, 1'b0);

        // Address wrap and empty transfer.
        run_xfer(16'hFFFE, 16'd4, 0, 1'b0);
        run_xfer(16'h1234, 16'd0, 0, 1'b0);

        // Reset after two bytes of an eight-byte transfer.
        start     = 1'b1;
        base_addr = 16'h0200;
        length    = 16'd8;
        out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        hs = 0;
        for (int c = 0; c < 20 && hs < 2; c++) begin
            @(negedge clk);
            if (out_valid && out_ready) hs++;
            @(posedge clk); #1;
        end
        check("rst_test_two_bytes", hs, 2);
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy", busy, 1'b0);
        check("midrst_mem_addr", mem_addr, 16'h0000);
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_out_data", out_data, 8'h00);
        check("midrst_checksum", checksum, 16'h0000);
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("midrst_no_done", done, 1'b0);
        end
        @(posedge clk); #1;
        run_xfer(16'h0300, 16'd5, 0, 1'b0);

        // Conflicting start mid-transfer is ignored.
        run_xfer(16'h0500, 16'd10, 0, 1'b1);

        // Random transfers under random backpressure.
        for (int t = 0; t < 6; t++) begin
            run_xfer(16'($urandom), 16'($urandom_range(1, 20)), 2, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stream_reader.md
# mem_stream_reader

Sequential read-out engine downstream of the byte-wide data memory. On a `start` command it walks a contiguous address range of data memory and presents each byte on a valid/ready output stream, sustaining one byte per cycle despite the memory's one-cycle read latency and arbitrary downstream backpressure. While busy it owns the data-memory address port; top-level muxing selects its address over the CPU's `alu_rslt[15:0]`. Typical consumers are UART/VGA/debug dump sinks.

## Interface
- `ADDR_W`, 16, data-memory address width
- `DATA_W`, 8, data-memory byte width
- `clk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  reset, synchronous, active-low
- `start`  in  1  command pulse; sampled only in IDLE
- `base_addr`  in  ADDR_W  first address, captured on accepted `start`
- `length`  in  ADDR_W  byte count, captured on accepted `start`; 0 is legal
- `mem_req`  out  1  high while streamer owns memory address port (= `busy`)
- `mem_addr`  out  ADDR_W  read address to data memory
- `mem_data`  in  DATA_W  data memory read data, valid the cycle after `mem_addr`
- `out_data`  out  DATA_W  stream byte
- `out_valid`  out  1  stream byte valid
- `out_ready`  in  1  consumer accepts when `out_valid && out_ready`
- `busy`  out  1  transfer in progress
- `done`  out  1  one-cycle pulse at transfer completion
- `checksum`  out  16  running byte sum (see Configuration)

## Operation
- FSM states: IDLE, RUN, DRAIN, FINISH.
- IDLE: `start`=1 captures `base_addr`/`length`; `length`≠0 → RUN, `length`=0 → FINISH.
- RUN: issue one read per cycle when `issue_left>0` and `fifo_count + pending − pop < 2`; issue drives `mem_addr`, sets `pending`, increments address, decrements `issue_left`. When `issue_left` reaches 0 → DRAIN.
- `pending` captured into 2-entry FIFO the following cycle (unconditionally; space guaranteed by issue rule).
- DRAIN: no issues; when FIFO empty, `pending`=0 and last handshake done → FINISH.
- FINISH: `done`=1 for one cycle, `busy`=0, → IDLE.
- `out_valid` = FIFO non-empty; `out_data` = FIFO head; pop on handshake.
- Address wraps 0xFFFF → 0x0000 silently; `length` up to 0xFFFF.
- `start` while not IDLE ignored; `base_addr`/`length` changes after capture ignored.
- `mem_addr` holds last issued address when not issuing; 0 in IDLE.

## Timing
- Reset (`rst`=0 at an edge): state IDLE, `busy`=0, `mem_req`=0, `mem_addr`=0, `out_valid`=0, `out_data`=0, `done`=0, `checksum`=0, FIFO flushed, `pending`=0. Reset mid-transfer aborts with no `done`.
- `start` sampled at edge E0: cycle 1 first `mem_addr`=base, `busy`=1; cycle 2 `mem_data` captured; cycle 3 first `out_valid`=1. Latency 3 cycles.
- `out_ready` held high: one byte per cycle; N bytes → last handshake in cycle N+2, `done` in cycle N+3, `busy` low in cycle N+3.
- Backpressure: `out_data` stable while `out_valid && !out_ready`; at most 2 bytes buffered plus 1 pending; no byte lost or duplicated.
- `length`=0: `done` in cycle 1 after start, `busy` stays 0, no `out_valid`.

## Configuration
- `MEM_STREAM_CHECKSUM_EN` defined: `checksum` = 16-bit wrap-around sum of all bytes handshaken in current transfer; cleared on accepted `start`; final value valid from `done` cycle until next `start`.
- Not defined: `checksum` tied 0, accumulator not built.

## Structure
- Package `mem_stream_pkg`: `ADDR_W`, `DATA_W` constants, `stream_state_t` enum (IDLE, RUN, DRAIN, FINISH).
- Sub-module `stream_fifo2`: 2-entry FIFO with push/pop/count/head, synchronous active-low reset on `rst`; simultaneous push and pop when full or empty handled (push into empty with pop does not pass through same cycle).

## Test plan
- Memory preloaded 0x10..0x13 at 0x0040; start base=0x0040 len=4, ready=1 → bytes 0x10,0x11,0x12,0x13 in cycles 3–6, `done` cycle 7, checksum 0x0046.
- Same, ready toggling 1,0,0,1,… → same byte order, no loss/duplication, `out_data` stable during stalls, FIFO never overflows.
- base=0xFFFE len=4 → addresses 0xFFFE,0xFFFF,0x0000,0x0001 read in order.
- len=0 → `done` one cycle after start, no `out_valid`, `busy` never high.
- `rst`=0 after 2 bytes of len=8 → all outputs 0 next cycle, no `done`; fresh start afterwards streams correctly from new base.
- `start` pulsed mid-transfer with different base → ignored; original stream completes unchanged.
